seq_chunk_adder: RTL
====================

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 2.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request; sampled only in IDLE or DONE.
REQ-006 sub  in  1  0 = inp1+inp2, 1 = inp1-inp2; captured with start.
REQ-007 inp1, inp2  in  WIDTH  operands; captured with start.
REQ-008 busy  out  1  high while state is RUN.
REQ-009 done  out  1  one-cycle pulse, high while state is DONE.
REQ-010 out  out  WIDTH  result; held from DONE until the next accepted start.
REQ-011 c_msb  out  1  carry into bit WIDTH-1.
REQ-012 c_out  out  1  carry out of bit WIDTH-1; for sub this is the no-borrow flag.
REQ-013 ovf  out  1  signed overflow, c_msb XOR c_out.

Function
REQ-014 States SHALL be IDLE, RUN and DONE; NSLICE = WIDTH/CHUNK.
REQ-015 IDLE: start=1 captures inp1, inp2 and sub, clears the slice counter, and moves to RUN; start=0 stays in IDLE.
REQ-016 Operand B SHALL be inp2 when sub=0 and ~inp2 when sub=1; initial carry-in SHALL equal sub.
REQ-017 RUN: each edge adds slice k (bits k*CHUNK+CHUNK-1..k*CHUNK) with the registered carry, writes the sum slice into out, and registers the slice carry-out; k runs 0 to NSLICE-1, LSB first.
REQ-018 On the edge that processes slice NSLICE-1, the block SHALL update c_out, c_msb and ovf and move to DONE.
REQ-019 c_msb SHALL equal out[WIDTH-1] XOR A[WIDTH-1] XOR B[WIDTH-1], using the captured operands.
REQ-020 done SHALL be high for exactly one cycle, NSLICE edges after the edge that accepted start.
REQ-021 DONE: start=1 accepts a new operation (go to RUN); start=0 goes to IDLE.
REQ-022 start SHALL be ignored while in RUN; the captured operands are not disturbed.
REQ-023 Input changes to inp1, inp2 or sub after capture SHALL NOT affect the operation in progress.
REQ-024 out, c_msb, c_out and ovf SHALL hold their final values in IDLE until the next accepted start.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-026 rst=1 SHALL force state IDLE and clear busy, done, out, c_msb, c_out, ovf, the slice counter, the carry register and the captured operands, all to 0.
REQ-027 rst during RUN SHALL abort the operation; done SHALL NOT pulse for it.
REQ-028 rst SHALL take priority over start on the same edge.

Structure
REQ-029 State encoding (IDLE=0, RUN=1, DONE=2) and the default WIDTH/CHUNK values SHALL live in the shared adder package/header.
REQ-030 One sub-module, chunk_adder, SHALL be used: a combinational CHUNK-bit ripple adder with carry-in and carry-out, instantiated once.
REQ-031 The slice counter SHALL be sized to hold values 0 to NSLICE-1.

Verification
REQ-032 WIDTH=32, CHUNK=8, sub=0, inp1=inp2=0x7FFFFFFF -> after 4 cycles done=1, out=0xFFFFFFFE, c_msb=1, c_out=0, ovf=1.
REQ-033 sub=0, 0xFFFFFFFF + 0x00000001 -> out=0x00000000, c_out=1, c_msb=1, ovf=0; carry propagates across all 4 slices.
REQ-034 sub=1, 0x80000000 - 0x00000001 -> out=0x7FFFFFFF, c_out=1, c_msb=0, ovf=1.
REQ-035 start held high continuously while feeding new operands each cycle during RUN -> the operands present at the accepting edge are used; in-RUN operand changes are ignored; a new op is accepted in the DONE cycle, giving done every 5 cycles.
REQ-036 rst asserted in RUN cycle 2 -> next cycle all outputs are 0, state is IDLE, and no done pulse occurs.
REQ-037 WIDTH=16, CHUNK=4, randomized 1000 ops -> out, c_out and ovf match a reference model; latency is 4.

Source files
------------

// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the sequential chunked adder:
// FSM state encoding and default operand/slice widths.
package seq_chunk_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle of the sequential chunked adder.
// master: start/sub/inp1/inp2 out, status and result in; slave: reverse.
interface seq_chunk_adder_if
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             c_msb;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, inp1, inp2,
        input  busy, done, out, c_msb, c_out, ovf
    );

    modport slave (
        input  start, sub, inp1, inp2,
        output busy, done, out, c_msb, c_out, ovf
    );
endinterface

// File: rtl/seq_chunk_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder.
// Ports: i_a, i_b operands, i_cin carry-in, o_sum sum, o_cout carry-out.
module chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);
    logic w_c;

    always_comb begin
        w_c   = i_cin;
        o_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first.
// Ports: clk, rst (sync, active high), io_bus (slave side of the bundle).
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic           clk,
    input  logic           rst,
    seq_chunk_adder_if.slave io_bus
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cmsb;
    logic             r_cout;
    logic             r_ovf;

    int               w_base;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;

    assign w_base = int'(r_cnt) * CHUNK;
    assign w_a    = r_a[w_base +: CHUNK];
    assign w_b    = r_b[w_base +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cmsb  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (io_bus.start) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry.
                        r_a     <= io_bus.inp1;
                        r_b     <= io_bus.sub ? ~io_bus.inp2
                                              : io_bus.inp2;
                        r_carry <= io_bus.sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_out[w_base +: CHUNK] <= w_sum;
                    r_carry                <= w_cout;
                    if (r_cnt == LAST) begin
                        // Carry into the MSB recovered from its sum bit.
                        r_cmsb  <= w_sum[CHUNK-1] ^ w_a[CHUNK-1]
                                 ^ w_b[CHUNK-1];
                        r_cout  <= w_cout;
                        r_ovf   <= w_sum[CHUNK-1] ^ w_a[CHUNK-1]
                                 ^ w_b[CHUNK-1] ^ w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.busy  = r_busy;
    assign io_bus.done  = r_done;
    assign io_bus.out   = r_out;
    assign io_bus.c_msb = r_cmsb;
    assign io_bus.c_out = r_cout;
    assign io_bus.ovf   = r_ovf;
endmodule
